// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared coin codes and coin acceptor state encoding
package vm_pkg;

  // Coin codes, shared with the vending FSM
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEB_HI   = 3'd1,
    MEASURE  = 3'd2,
    DEB_LO   = 3'd3,
    CLASSIFY = 3'd4,
    JAM      = 3'd5,
    LOCKOUT  = 3'd6
  } acc_state_e;

endpackage

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - coin acceptor to vending FSM link
interface coin_acceptor_if;
  import vm_pkg::*;

  logic       enable;
  logic [1:0] coin;
  logic       reject;
  logic       busy;

  // Vending side: grants acceptance, consumes results
  modport master (output enable, input coin, input reject, input busy);
  // Acceptor side
  modport slave  (input enable, output coin, output reject, output busy);
endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser for an asynchronous level input
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the raw level through STAGES flops; reset clears to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounces the slot sensor and classifies coins by beam width
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int W_MIN1       = 8,
  parameter int W_MAX1       = 15,
  parameter int W_MIN2       = 20,
  parameter int W_MAX2       = 31,
  parameter int LOCKOUT_CYC  = 8,
  parameter int CNT_W        = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sense_in,
  coin_acceptor_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEB_C       = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] MIN1_C      = CNT_W'(W_MIN1);
  localparam logic [CNT_W-1:0] MAX1_C      = CNT_W'(W_MAX1);
  localparam logic [CNT_W-1:0] MIN2_C      = CNT_W'(W_MIN2);
  localparam logic [CNT_W-1:0] MAX2_C      = CNT_W'(W_MAX2);
  localparam logic [CNT_W-1:0] JAM_C       = CNT_W'(W_MAX2 + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST_C = CNT_W'(LOCKOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

  logic             sense_s;
  acc_state_e       state, state_nxt;
  logic [CNT_W-1:0] wcnt, wcnt_nxt, wcnt_inc;
  logic [CNT_W-1:0] dcnt, dcnt_nxt, dcnt_inc;
  logic [1:0]       coin_q, coin_nxt;
  logic             reject_q, reject_nxt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sense_in),
    .q     (sense_s)
  );

  // Width counter saturates so it can never wrap into a valid band
  assign wcnt_inc = (wcnt == {CNT_W{1'b1}}) ? wcnt : wcnt + ONE_C;
  assign dcnt_inc = (dcnt == {CNT_W{1'b1}}) ? dcnt : dcnt + ONE_C;

  // Next-state, counter and result decode
  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    dcnt_nxt   = dcnt;
    coin_nxt   = COIN_NONE;
    reject_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sense_s) begin
          state_nxt = DEB_HI;
          wcnt_nxt  = ONE_C;
        end
      end
      DEB_HI: begin
        if (!sense_s) begin
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt = wcnt_inc;
          if (wcnt_inc >= DEB_C) state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (!sense_s) begin
          state_nxt = DEB_LO;
          dcnt_nxt  = ONE_C;
        end else begin
          wcnt_nxt = wcnt_inc;
          if (wcnt_inc >= JAM_C) begin
            state_nxt  = JAM;
            reject_nxt = 1'b1;
            dcnt_nxt   = '0;
          end
        end
      end
      DEB_LO: begin
        if (sense_s) begin
          // A short low was a glitch inside the coin: resume counting
          wcnt_nxt = wcnt_inc;
          if (wcnt_inc >= JAM_C) begin
            state_nxt  = JAM;
            reject_nxt = 1'b1;
            dcnt_nxt   = '0;
          end else begin
            state_nxt = MEASURE;
          end
        end else begin
          dcnt_nxt = dcnt_inc;
          if (dcnt_inc >= DEB_C) state_nxt = CLASSIFY;
        end
      end
      CLASSIFY: begin
        state_nxt = LOCKOUT;
        dcnt_nxt  = '0;
        if (!bus.enable) begin
          reject_nxt = 1'b1;
        end else if (wcnt >= MIN1_C && wcnt <= MAX1_C) begin
          coin_nxt = COIN_1;
        end else if (wcnt >= MIN2_C && wcnt <= MAX2_C) begin
          coin_nxt = COIN_2;
        end else begin
          reject_nxt = 1'b1;
        end
      end
      JAM: begin
        // Wait for the beam to stay clear before re-arming
        if (sense_s) begin
          dcnt_nxt = '0;
        end else if (dcnt_inc >= DEB_C) begin
          state_nxt = LOCKOUT;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt = dcnt_inc;
        end
      end
      LOCKOUT: begin
        if (dcnt >= LOCK_LAST_C) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
          wcnt_nxt  = '0;
        end else begin
          dcnt_nxt = dcnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
        dcnt_nxt  = '0;
      end
    endcase
  end

  // State, counters and registered result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wcnt     <= '0;
      dcnt     <= '0;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      dcnt     <= dcnt_nxt;
      coin_q   <= coin_nxt;
      reject_q <= reject_nxt;
    end
  end

  assign bus.coin   = coin_q;
  assign bus.reject = reject_q;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed self-checking bench for coin_acceptor
module tb_coin_acceptor;

  logic clk;
  logic rst_n;
  logic sense_in;
  int   ncmp;
  int   nfail;

  coin_acceptor_if bus ();

  coin_acceptor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sense_in (sense_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One directed scenario. sense_in is high for hi1 cycles, low for gap,
  // high for hi2, then low. Cycle index k means "just after the k-th edge
  // counted from the rise". Event code = {reject, coin}.
  task automatic run(input string tag, input int hi1, input int gap, input int hi2,
                     input logic en_a, input int en_cut, input int rst_at,
                     input int exp_n, input int e0_idx, input int e0_code,
                     input int e1_idx, input int e1_code, input int exp_bdown);
    int total, n, bup, bdown, bad, idx;
    int ev_i[2];
    int ev_c[2];
    total = hi1 + gap + hi2;
    n = 0; bup = -1; bdown = -1; bad = 0;
    ev_i[0] = -1; ev_i[1] = -1; ev_c[0] = -1; ev_c[1] = -1;
    for (int i = 0; i < total + 30; i++) begin
      sense_in   = (i < hi1) || (i >= hi1 + gap && i < total);
      bus.enable = (i < en_cut) ? en_a : 1'b1;
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_coin"},   int'(bus.coin),   0);
        chk({tag, ".rst_reject"}, int'(bus.reject), 0);
        chk({tag, ".rst_busy"},   int'(bus.busy),   0);
      end
      if (i == rst_at + 2) rst_n = 1'b1;
      cyc(1);
      idx = i + 1;
      if (bus.coin != 2'b00 || bus.reject) begin
        if (n < 2) begin
          ev_i[n] = idx;
          ev_c[n] = int'({bus.reject, bus.coin});
        end
        n++;
      end
      if (bus.coin == 2'b11 || (bus.coin != 2'b00 && bus.reject)) bad++;
      if (bus.busy && bup < 0) bup = idx;
      if (!bus.busy && idx > total && bdown < 0) bdown = idx;
    end
    sense_in   = 1'b0;
    bus.enable = 1'b1;
    chk({tag, ".events"},    n,     exp_n);
    chk({tag, ".busy_up"},   bup,   3);
    chk({tag, ".busy_down"}, bdown, exp_bdown);
    chk({tag, ".illegal"},   bad,   0);
    if (exp_n > 0) begin
      chk({tag, ".ev0_cycle"}, ev_i[0], e0_idx);
      chk({tag, ".ev0_code"},  ev_c[0], e0_code);
    end
    if (exp_n > 1) begin
      chk({tag, ".ev1_cycle"}, ev_i[1], e1_idx);
      chk({tag, ".ev1_code"},  ev_c[1], e1_code);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clk        = 1'b0;
    ncmp       = 0;
    nfail      = 0;
    rst_n      = 1'b0;
    sense_in   = 1'b0;
    bus.enable = 1'b1;
    cyc(3);
    chk("reset.coin",   int'(bus.coin),   0);
    chk("reset.reject", int'(bus.reject), 0);
    chk("reset.busy",   int'(bus.busy),   0);
    rst_n = 1'b1;
    cyc(2);

    // Rs.1 / Rs.2 bands and their edges: result 7 cycles after the fall,
    // busy clears 15 cycles after the fall
    run("w10", 10, 0, 0, 1'b1, 0, -10, 1, 17, 1, 0, 0, 25);
    run("w25", 25, 0, 0, 1'b1, 0, -10, 1, 32, 2, 0, 0, 40);
    run("w8",   8, 0, 0, 1'b1, 0, -10, 1, 15, 1, 0, 0, 23);
    run("w15", 15, 0, 0, 1'b1, 0, -10, 1, 22, 1, 0, 0, 30);
    run("w20", 20, 0, 0, 1'b1, 0, -10, 1, 27, 2, 0, 0, 35);
    run("w31", 31, 0, 0, 1'b1, 0, -10, 1, 38, 2, 0, 0, 46);
    run("w7",   7, 0, 0, 1'b1, 0, -10, 1, 14, 4, 0, 0, 22);
    run("w16", 16, 0, 0, 1'b1, 0, -10, 1, 23, 4, 0, 0, 31);
    run("w19", 19, 0, 0, 1'b1, 0, -10, 1, 26, 4, 0, 0, 34);

    // Short glitch: no result, back to IDLE 3 cycles after the fall
    run("glitch", 2, 0, 0, 1'b1, 0, -10, 0, 0, 0, 0, 0, 5);
    // 6 high, 2 low, 6 high: the dip is absorbed, W = 12
    run("split", 6, 2, 6, 1'b1, 0, -10, 1, 21, 1, 0, 0, 29);
    // Held 50 cycles: single reject when W hits 32, then debounce + lockout
    run("jam", 50, 0, 0, 1'b1, 0, -10, 1, 34, 4, 0, 0, 64);
    // enable low at classification
    run("en0", 10, 0, 0, 1'b0, 1000, -10, 1, 17, 4, 0, 0, 25);
    // Second coin arrives during lockout: only highs after lockout count (W = 12)
    run("lockout", 10, 5, 20, 1'b0, 20, -10, 2, 17, 4, 42, 1, 50);
    // Reset mid-measure at W = 12, sense still high: re-measured as W = 14
    run("reset", 30, 0, 0, 1'b1, 0, 14, 1, 37, 1, 0, 0, 45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
